// File: rtl/des_pkg.sv
// Constant tables and combinational helpers for the DES cipher core.
// Tables are stored MSB-first: entry 1 sits in the top byte (or nibble).
package des_pkg;

    localparam logic [511:0] IP_T = {
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
        8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
        8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7
    };

    localparam logic [511:0] FP_T = {
        8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
        8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
        8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
        8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
        8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
        8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
        8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
        8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25
    };

    // Shorter tables are zero-padded at the bottom to a common 64-entry shape.
    localparam logic [511:0] E_T = {
        8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,
        8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
        8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13,
        8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
        8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21,
        8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
        8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29,
        8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1,
        {16{8'd0}}
    };

    localparam logic [511:0] P_T = {
        8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
        8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
        8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
        8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25,
        {32{8'd0}}
    };

    localparam logic [511:0] PC1_T = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
        8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
        8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
        8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
        8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4,
        {8{8'd0}}
    };

    localparam logic [511:0] PC2_T = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
        8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
        8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
        8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
        8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32,
        {16{8'd0}}
    };

    localparam logic [31:0] ROT_SCHED = {
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // S1..S8, four rows each, sixteen 4-bit entries per row.
    localparam logic [2047:0] SBOX = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // DES bit t of an n_in-bit input is din[n_in-t]; result is right-aligned.
    function automatic logic [63:0] permute(input logic [63:0] din, input int n_in,
                                            input int n_out, input logic [511:0] tbl);
        logic [63:0] dout;
        logic [7:0]  src;
        dout = 64'h0;
        for (int j = 0; j < 64; j++) begin
            src = tbl[9'(8 * (63 - j)) +: 8];
            if (j < n_out) begin
                dout[6'(n_out - 1 - j)] = din[6'(n_in - int'(src))];
            end
        end
        return dout;
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [2:0] s, input logic [5:0] b);
        logic [8:0] n;
        n = {s, b[5], b[0], b[4:1]};
        return SBOX[{~n, 2'b11} -: 4];
    endfunction

    function automatic logic [31:0] f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s_out;
        logic [5:0]  six;
        x = 48'(permute({32'h0, r}, 32, 48, E_T)) ^ k;
        s_out = 32'h0;
        for (int i = 0; i < 8; i++) begin
            six = x[6'(47 - 6 * i) -: 6];
            s_out[5'(31 - 4 * i) -: 4] = sbox_lookup(3'(i), six);
        end
        return 32'(permute({32'h0, s_out}, 32, 32, P_T));
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    // Cumulative left rotation applied to C/D before round (idx+1).
    function automatic int rot_total(input int idx);
        int sum;
        sum = 0;
        for (int j = 0; j < 16; j++) begin
            if (j <= idx) begin
                sum += int'(ROT_SCHED[5'(2 * (15 - j)) +: 2]);
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational Feistel round: L' = R, R' = L ^ f(R, K).
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] l_next,
    output logic [31:0] r_next
);

    assign l_next = r;
    assign r_next = l ^ f(r, k);

endmodule

// File: rtl/des_top.sv
// Single-cycle DES encrypt/decrypt core: 16 unrolled rounds feeding one output register.
// Each subkey is derived straight from PC-1 by its cumulative rotation, so decrypt just picks the mirrored amount.
module des_top
    import des_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        DECRYPT,
    input  logic [63:0] KEY,
    input  logic [63:0] TEXT_IN,
    output logic [63:0] TEXT_OUT
);

    logic [55:0] pc1_s;
    logic [27:0] c0_s;
    logic [27:0] d0_s;
    logic [47:0] round_key_s [0:15];
    logic [63:0] ip_s;
    logic [63:0] preout_s;
    logic [63:0] fp_s;
    logic [63:0] text_out_r;

    assign pc1_s = 56'(permute(KEY, 64, 56, PC1_T));
    assign c0_s  = pc1_s[55:28];
    assign d0_s  = pc1_s[27:0];

    for (genvar i = 0; i < 16; i++) begin : g_key
        localparam int ENC_ROT = rot_total(i);
        localparam int DEC_ROT = rot_total(15 - i);
        logic [55:0] cd_s;
        assign cd_s = DECRYPT ? {rotl28(c0_s, DEC_ROT), rotl28(d0_s, DEC_ROT)}
                              : {rotl28(c0_s, ENC_ROT), rotl28(d0_s, ENC_ROT)};
        assign round_key_s[i] = 48'(permute({8'h0, cd_s}, 56, 48, PC2_T));
    end

    assign ip_s = permute(TEXT_IN, 64, 64, IP_T);

    for (genvar i = 0; i < 16; i++) begin : g_round
        logic [31:0] l_in_s;
        logic [31:0] r_in_s;
        logic [31:0] l_out_s;
        logic [31:0] r_out_s;
        if (i == 0) begin : g_first
            assign l_in_s = ip_s[63:32];
            assign r_in_s = ip_s[31:0];
        end else begin : g_next
            assign l_in_s = g_round[i - 1].l_out_s;
            assign r_in_s = g_round[i - 1].r_out_s;
        end
        des_round u_round (
            .l      (l_in_s),
            .r      (r_in_s),
            .k      (round_key_s[i]),
            .l_next (l_out_s),
            .r_next (r_out_s)
        );
    end

    // Final swap: R16 goes in front of L16 ahead of the inverse permutation.
    assign preout_s = {g_round[15].r_out_s, g_round[15].l_out_s};
    assign fp_s     = permute(preout_s, 64, 64, FP_T);

    // Output register: cleared asynchronously, otherwise captures this cycle's result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            text_out_r <= 64'h0;
        end else begin
            text_out_r <= fp_s;
        end
    end

    assign TEXT_OUT = text_out_r;

endmodule

// File: tb/tb_des_top.sv
// Directed scoreboard bench for des_top: known-answer vectors back-to-back,
// reset behaviour, and an encrypt->decrypt chained pair of instances.
module tb_des_top;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DECRYPT;
    logic [63:0] KEY;
    logic [63:0] TEXT_IN;
    logic [63:0] TEXT_OUT;

    logic [63:0] chain_key;
    logic [63:0] chain_pt;
    logic [63:0] chain_mid;
    logic [63:0] chain_out;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q [$];
    logic [63:0] chain_q [$];

    logic [63:0] vk [7];
    logic [63:0] vt [7];
    logic [63:0] ve [7];
    logic        vd [7];

    always #60 CLK = ~CLK;

    des_top dut (
        .CLK      (CLK),
        .RST      (RST),
        .DECRYPT  (DECRYPT),
        .KEY      (KEY),
        .TEXT_IN  (TEXT_IN),
        .TEXT_OUT (TEXT_OUT)
    );

    des_top u_enc (
        .CLK      (CLK),
        .RST      (RST),
        .DECRYPT  (1'b0),
        .KEY      (chain_key),
        .TEXT_IN  (chain_pt),
        .TEXT_OUT (chain_mid)
    );

    des_top u_dec (
        .CLK      (CLK),
        .RST      (RST),
        .DECRYPT  (1'b1),
        .KEY      (chain_key),
        .TEXT_IN  (chain_mid),
        .TEXT_OUT (chain_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on both paths, then compare after the edge.
    task automatic cycle(input logic [63:0] k, input logic [63:0] t, input logic d,
                         input logic [63:0] e, input logic [63:0] pt, input string tag);
        @(negedge CLK);
        KEY      = k;
        TEXT_IN  = t;
        DECRYPT  = d;
        chain_pt = pt;
        exp_q.push_back(e);
        chain_q.push_back(pt);
        @(posedge CLK);
        #1;
        check(tag, TEXT_OUT, exp_q.pop_front());
        if (chain_q.size() >= 2) begin
            check({tag, "_chain"}, chain_out, chain_q.pop_front());
        end
    endtask

    initial begin
        vk[0] = 64'h133457799BBCDFF1; vt[0] = 64'h0123456789ABCDEF; vd[0] = 1'b0; ve[0] = 64'h85E813540F0AB405;
        vk[1] = 64'h133457799BBCDFF1; vt[1] = 64'h85E813540F0AB405; vd[1] = 1'b1; ve[1] = 64'h0123456789ABCDEF;
        vk[2] = 64'h0E329232EA6D0D73; vt[2] = 64'h8787878787878787; vd[2] = 1'b0; ve[2] = 64'h0000000000000000;
        vk[3] = 64'h0000000000000000; vt[3] = 64'h0000000000000000; vd[3] = 1'b0; ve[3] = 64'h8CA64DE9C1B123A7;
        vk[4] = 64'h123457799ABCDFF0; vt[4] = 64'h0123456789ABCDEF; vd[4] = 1'b0; ve[4] = 64'h85E813540F0AB405;
        vk[5] = 64'h0E329232EA6D0D73; vt[5] = 64'h0000000000000000; vd[5] = 1'b1; ve[5] = 64'h8787878787878787;
        vk[6] = 64'h0000000000000000; vt[6] = 64'h8CA64DE9C1B123A7; vd[6] = 1'b1; ve[6] = 64'h0000000000000000;

        RST       = 1'b0;
        DECRYPT   = 1'b0;
        KEY       = vk[0];
        TEXT_IN   = vt[0];
        chain_key = 64'h133457799BBCDFF1;
        chain_pt  = 64'h0123456789ABCDEF;
        #2 RST = 1'b1;
        #1;
        check("rst_async", TEXT_OUT, 64'h0);
        check("rst_async_enc", chain_mid, 64'h0);
        check("rst_async_dec", chain_out, 64'h0);
        @(posedge CLK);
        #1;
        check("rst_hold", TEXT_OUT, 64'h0);
        check("rst_hold_dec", chain_out, 64'h0);
        @(negedge CLK);
        RST = 1'b0;

        cycle(vk[0], vt[0], vd[0], ve[0], 64'h0123456789ABCDEF, "first");
        check("chain_enc", chain_mid, 64'h85E813540F0AB405);

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 7; i++) begin
                cycle(vk[i], vt[i], vd[i], ve[i], {$urandom, $urandom}, $sformatf("fwd%0d_v%0d", p, i));
            end
        end
        for (int i = 6; i >= 0; i--) begin
            cycle(vk[i], vt[i], vd[i], ve[i], {$urandom, $urandom}, $sformatf("rev_v%0d", i));
        end

        // Mid-cycle reset: output must clear at once and stay clear across an edge.
        @(negedge CLK);
        KEY     = vk[3];
        TEXT_IN = vt[3];
        DECRYPT = vd[3];
        @(posedge CLK);
        #20;
        RST = 1'b1;
        #1;
        check("rst_mid", TEXT_OUT, 64'h0);
        check("rst_mid_dec", chain_out, 64'h0);
        @(posedge CLK);
        #1;
        check("rst_mid_hold", TEXT_OUT, 64'h0);
        @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        chain_q.delete();

        for (int i = 0; i < 7; i++) begin
            cycle(vk[i], vt[i], vd[i], ve[i], {$urandom, $urandom}, $sformatf("post_v%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
